// File: rtl/i2s_to_wb_pkg.sv
// Shared definitions for the I2S-to-Wishbone bridge.
//   dma_state_e        : DMA engine bus-cycle state (IDLE, WRITE)
//   WB_SEL_ALL         : byte-select value for full 32-bit transfers
//   WB_DATA_W          : Wishbone data width
//   FIFO_DEPTH_DEFAULT : default sample FIFO depth in words
package i2s_to_wb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } dma_state_e;

   localparam logic [3:0]  WB_SEL_ALL         = 4'b1111;
   localparam int unsigned WB_DATA_W          = 32;
   localparam int unsigned FIFO_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with head-word look-ahead.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : empty the FIFO on the next edge (wins over push/pop)
//   push, din  : write strobe and data; dropped when full unless popping
//   pop        : discard the head word; ignored when empty
//   dout       : current head word
//   full,empty : occupancy flags, derived from the registered count
module sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   // Pointers wrap explicitly so non-power-of-two depths also work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a push while full is accepted.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // Storage array; not reset.
   always_ff @(posedge clk) begin
      if (do_push && !rst && !flush) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/i2s_to_wb_rx_dma.sv
// Receive DMA: buffers I2S samples and writes them as a Wishbone master
// into a circular buffer in system memory.
//   i2s_clk_i, i2s_rst_i          : clock, synchronous active-high reset
//   fifo_push, fifo_data_i        : sample strobe/data from the receiver
//   fifo_full                     : sample FIFO full
//   i2s_enable                    : permits new bus cycles
//   wbm_*                         : Wishbone master write port
//   dma_wr_pointer_i/_we          : buffer base load (restarts the engine)
//   dma_wr_pointer_o              : current write address
//   dma_word_size, dma_buffer_size: byte increment and buffer length
//   dma_half_o, dma_wrap_o        : one-cycle buffer progress events
//   dma_overflow_error            : sticky FIFO overrun
//   dma_bus_error                 : sticky Wishbone error
module i2s_to_wb_rx_dma
   import i2s_to_wb_pkg::*;
#(
   parameter int unsigned DMA_BUFFER_MAX_WIDTH = 12,
   parameter int unsigned FIFO_DEPTH           = FIFO_DEPTH_DEFAULT
) (
   input  logic                            i2s_clk_i,
   input  logic                            i2s_rst_i,
   input  logic                            fifo_push,
   input  logic [31:0]                     fifo_data_i,
   output logic                            fifo_full,
   input  logic                            i2s_enable,
   output logic [31:0]                     wbm_data_o,
   output logic [31:0]                     wbm_addr_o,
   output logic [3:0]                      wbm_sel_o,
   output logic                            wbm_we_o,
   output logic                            wbm_cyc_o,
   output logic                            wbm_stb_o,
   input  logic                            wbm_ack_i,
   input  logic                            wbm_err_i,
   input  logic [31:0]                     dma_wr_pointer_i,
   input  logic                            dma_wr_pointer_we,
   output logic [31:0]                     dma_wr_pointer_o,
   input  logic [DMA_BUFFER_MAX_WIDTH-1:0] dma_word_size,
   input  logic [DMA_BUFFER_MAX_WIDTH-1:0] dma_buffer_size,
   output logic                            dma_half_o,
   output logic                            dma_wrap_o,
   output logic                            dma_overflow_error,
   output logic                            dma_bus_error
);

   localparam int unsigned W  = DMA_BUFFER_MAX_WIDTH;
   localparam int unsigned OW = W + 1;

   dma_state_e     state_q;
   dma_state_e     state_d;
   logic [31:0]    base_q;
   logic [OW-1:0]  offset_q;
   logic           half_q;
   logic           wrap_q;
   logic           ovf_q;
   logic           berr_q;

   logic           fifo_empty;
   logic [31:0]    fifo_head;
   logic           bus_done;
   logic [OW-1:0]  base_low;
   logic [OW-1:0]  end_off;
   logic [OW-1:0]  half_off;
   logic [OW-1:0]  next_off;
   logic           wrap_hit;
   logic           half_hit;

   // A cycle ends on ack or err; either way the head word is consumed.
   assign bus_done = (state_q == WRITE) && (wbm_ack_i || wbm_err_i);

   sync_fifo #(
      .WIDTH (WB_DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (i2s_clk_i),
      .rst   (i2s_rst_i),
      .flush (dma_wr_pointer_we),
      .push  (fifo_push),
      .pop   (bus_done),
      .din   (fifo_data_i),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Offset arithmetic in W+1 bits so end-of-buffer compares cannot overflow.
   assign base_low = {1'b0, base_q[W-1:0]};
   assign end_off  = base_low + {1'b0, dma_buffer_size};
   assign half_off = base_low + OW'(dma_buffer_size >> 1);
   assign next_off = offset_q + {1'b0, dma_word_size};
   assign wrap_hit = (next_off >= end_off);
   assign half_hit = (offset_q < half_off) && (half_off <= next_off);

   // State register.
   always_ff @(posedge i2s_clk_i) begin
      if (i2s_rst_i) state_q <= IDLE;
      else           state_q <= state_d;
   end

   // Next-state logic; a base reload always returns to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i2s_enable && !fifo_empty)  state_d = WRITE;
         WRITE:   if (wbm_ack_i || wbm_err_i)     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (dma_wr_pointer_we) state_d = IDLE;
   end

   // Pointer, event pulses and sticky flags.
   always_ff @(posedge i2s_clk_i) begin
      if (i2s_rst_i) begin
         base_q   <= '0;
         offset_q <= '0;
         half_q   <= 1'b0;
         wrap_q   <= 1'b0;
         ovf_q    <= 1'b0;
         berr_q   <= 1'b0;
      end else if (dma_wr_pointer_we) begin
         base_q   <= dma_wr_pointer_i;
         offset_q <= {1'b0, dma_wr_pointer_i[W-1:0]};
         half_q   <= 1'b0;
         wrap_q   <= 1'b0;
         ovf_q    <= 1'b0;
         berr_q   <= 1'b0;
      end else begin
         half_q <= 1'b0;
         wrap_q <= 1'b0;
         if (bus_done) begin
            offset_q <= wrap_hit ? base_low : next_off;
            wrap_q   <= wrap_hit;
            half_q   <= half_hit;
            if (wbm_err_i) berr_q <= 1'b1;
         end
         if (fifo_push && fifo_full && !bus_done) ovf_q <= 1'b1;
      end
   end

   assign wbm_cyc_o          = (state_q == WRITE);
   assign wbm_stb_o          = (state_q == WRITE);
   assign wbm_we_o           = (state_q == WRITE);
   assign wbm_sel_o          = WB_SEL_ALL;
   assign wbm_data_o         = fifo_head;
   assign wbm_addr_o         = {base_q[31:W], offset_q[W-1:0]};
   assign dma_wr_pointer_o   = wbm_addr_o;
   assign dma_half_o         = half_q;
   assign dma_wrap_o         = wrap_q;
   assign dma_overflow_error = ovf_q;
   assign dma_bus_error      = berr_q;

endmodule

// File: tb/tb_i2s_to_wb_rx_dma.sv
// Bench for i2s_to_wb_rx_dma: random sample data and slave latency, checked
// against a model that places write k at base + (k mod N) * word_size.
module tb_i2s_to_wb_rx_dma;

   localparam int unsigned W     = 12;
   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          fifo_push = 1'b0;
   logic [31:0]   fifo_data_i = '0;
   logic          fifo_full;
   logic          i2s_enable = 1'b0;
   logic [31:0]   wbm_data_o;
   logic [31:0]   wbm_addr_o;
   logic [3:0]    wbm_sel_o;
   logic          wbm_we_o;
   logic          wbm_cyc_o;
   logic          wbm_stb_o;
   logic          wbm_ack_i = 1'b0;
   logic          wbm_err_i = 1'b0;
   logic [31:0]   dma_wr_pointer_i = '0;
   logic          dma_wr_pointer_we = 1'b0;
   logic [31:0]   dma_wr_pointer_o;
   logic [W-1:0]  dma_word_size = '0;
   logic [W-1:0]  dma_buffer_size = '0;
   logic          dma_half_o;
   logic          dma_wrap_o;
   logic          dma_overflow_error;
   logic          dma_bus_error;

   always #5 clk = ~clk;

   i2s_to_wb_rx_dma #(
      .DMA_BUFFER_MAX_WIDTH (W),
      .FIFO_DEPTH           (DEPTH)
   ) dut (
      .i2s_clk_i          (clk),
      .i2s_rst_i          (rst),
      .fifo_push          (fifo_push),
      .fifo_data_i        (fifo_data_i),
      .fifo_full          (fifo_full),
      .i2s_enable         (i2s_enable),
      .wbm_data_o         (wbm_data_o),
      .wbm_addr_o         (wbm_addr_o),
      .wbm_sel_o          (wbm_sel_o),
      .wbm_we_o           (wbm_we_o),
      .wbm_cyc_o          (wbm_cyc_o),
      .wbm_stb_o          (wbm_stb_o),
      .wbm_ack_i          (wbm_ack_i),
      .wbm_err_i          (wbm_err_i),
      .dma_wr_pointer_i   (dma_wr_pointer_i),
      .dma_wr_pointer_we  (dma_wr_pointer_we),
      .dma_wr_pointer_o   (dma_wr_pointer_o),
      .dma_word_size      (dma_word_size),
      .dma_buffer_size    (dma_buffer_size),
      .dma_half_o         (dma_half_o),
      .dma_wrap_o         (dma_wrap_o),
      .dma_overflow_error (dma_overflow_error),
      .dma_bus_error      (dma_bus_error)
   );

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
   endtask

   // Reference model state
   logic [31:0]  m_base = '0;
   int unsigned  m_ws = 4;
   int unsigned  m_size = 64;
   int unsigned  m_k = 0;
   logic [31:0]  exp_q[$];
   bit           ovf_exp = 0;
   bit           berr_exp = 0;

   // Slave behaviour
   bit           slave_en = 0;
   int unsigned  max_delay = 0;
   int           err_idx = -1;
   int unsigned  wait_cnt = 0;
   int unsigned  cur_delay = 0;
   bit           pend = 0;
   bit           pend_half = 0;
   bit           pend_wrap = 0;
   int unsigned  n_writes = 0;
   int unsigned  cyc_cnt = 0;
   int unsigned  term_q[$];

   always @(posedge clk) cyc_cnt++;

   // Wishbone slave: checks each write at the terminating cycle, then
   // checks the event pulses and the idle gap on the following cycle.
   always @(negedge clk) begin
      int unsigned n;
      int unsigned j;
      logic [31:0] ea;
      logic [31:0] ed;
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      if (pend) begin
         check_eq("half_pulse", {31'b0, dma_half_o}, {31'b0, pend_half});
         check_eq("wrap_pulse", {31'b0, dma_wrap_o}, {31'b0, pend_wrap});
         check_eq("cyc_gap", {31'b0, wbm_cyc_o}, 32'd0);
         pend = 0;
      end
      if (slave_en && wbm_cyc_o && wbm_stb_o) begin
         if (wait_cnt >= cur_delay) begin
            n  = m_size / m_ws;
            j  = m_k % n;
            ea = m_base + 32'(j * m_ws);
            if (exp_q.size() == 0) begin
               check_eq("spurious_write", {31'b0, wbm_cyc_o}, 32'd0);
               ed = '0;
            end else begin
               ed = exp_q.pop_front();
            end
            check_eq("wr_addr", wbm_addr_o, ea);
            check_eq("wr_ptr", dma_wr_pointer_o, ea);
            check_eq("wr_data", wbm_data_o, ed);
            check_eq("wr_sel_we", {27'b0, wbm_sel_o, wbm_we_o}, {27'b0, 4'hF, 1'b1});
            if (int'(m_k) == err_idx) begin
               wbm_err_i = 1'b1;
               berr_exp  = 1;
            end else begin
               wbm_ack_i = 1'b1;
            end
            pend      = 1;
            pend_half = (j * m_ws < m_size / 2) && ((j + 1) * m_ws >= m_size / 2);
            pend_wrap = (j == n - 1);
            term_q.push_back(cyc_cnt);
            m_k++;
            n_writes++;
            wait_cnt  = 0;
            cur_delay = $urandom_range(max_delay, 0);
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_geom(input int unsigned ws, input int unsigned size);
      m_ws            = ws;
      m_size          = size;
      dma_word_size   = W'(ws);
      dma_buffer_size = W'(size);
   endtask

   task automatic load_base(input logic [31:0] a);
      dma_wr_pointer_i  = a;
      dma_wr_pointer_we = 1'b1;
      tick();
      dma_wr_pointer_we = 1'b0;
      m_base   = a;
      m_k      = 0;
      exp_q.delete();
      ovf_exp  = 0;
      berr_exp = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_base   = '0;
      m_k      = 0;
      exp_q.delete();
      ovf_exp  = 0;
      berr_exp = 0;
   endtask

   // Only meaningful as an overrun when the slave is stalled.
   task automatic push_word(input logic [31:0] d);
      fifo_push   = 1'b1;
      fifo_data_i = d;
      if (exp_q.size() >= DEPTH && !slave_en) ovf_exp = 1;
      else exp_q.push_back(d);
      tick();
      fifo_push = 1'b0;
   endtask

   // Keeps occupancy below capacity so no word can be lost.
   task automatic push_flow(input logic [31:0] d);
      for (int i = 0; i < 200 && exp_q.size() >= 3; i++) tick();
      push_word(d);
   endtask

   task automatic wait_cyc(input string tag);
      for (int i = 0; i < 50 && !wbm_cyc_o; i++) tick();
      check_eq(tag, {31'b0, wbm_cyc_o}, 32'd1);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 3000 && (exp_q.size() != 0 || wbm_cyc_o || pend); i++) tick();
      check_eq({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
      check_eq({tag, "_flags"}, {30'b0, dma_overflow_error, dma_bus_error},
               {30'b0, ovf_exp, berr_exp});
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_ctl"}, {29'b0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 32'd0);
      check_eq({tag, "_addr"}, wbm_addr_o, 32'd0);
      check_eq({tag, "_ptr"}, dma_wr_pointer_o, 32'd0);
      check_eq({tag, "_full"}, {31'b0, fifo_full}, 32'd0);
      check_eq({tag, "_evt"}, {28'b0, dma_half_o, dma_wrap_o, dma_overflow_error, dma_bus_error}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned w0;
      bit          seen;
      logic [31:0] rnd;
      int unsigned ws, nw, bl, cnt;

      set_geom(4, 32'h40);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_state("reset");

      i2s_enable = 1'b1;
      load_base(32'h8000_0100);
      check_eq("load_ptr", dma_wr_pointer_o, 32'h8000_0100);

      // Basic: three writes, immediate ack, one idle cycle between writes
      slave_en  = 1;
      max_delay = 0;
      cur_delay = 0;
      term_q.delete();
      for (int i = 0; i < 3; i++) push_word($urandom());
      drain("basic");
      check_eq("basic_n", 32'(term_q.size()), 32'd3);
      if (term_q.size() == 3) begin
         check_eq("tput_01", term_q[1] - term_q[0], 32'd2);
         check_eq("tput_12", term_q[2] - term_q[1], 32'd2);
      end

      // Half and wrap over 17 words
      load_base(32'h8000_0100);
      max_delay = 1;
      for (int i = 0; i < 17; i++) push_flow($urandom());
      drain("halfwrap");
      check_eq("halfwrap_ptr", dma_wr_pointer_o, 32'h8000_0104);

      // Overrun with stalled slave
      load_base(32'h8000_0100);
      slave_en = 0;
      for (int i = 0; i < 6; i++) begin
         push_word($urandom());
         check_eq("ovr_full", {31'b0, fifo_full}, {31'b0, exp_q.size() >= DEPTH});
      end
      check_eq("ovr_flag", {31'b0, dma_overflow_error}, 32'd1);
      w0 = n_writes;
      slave_en = 1;
      drain("ovr");
      check_eq("ovr_nwrites", n_writes - w0, 32'd4);

      // Bus error on the second write
      load_base(32'h8000_0100);
      check_eq("berr_clr_ovf", {31'b0, dma_overflow_error}, 32'd0);
      err_idx = 1;
      for (int i = 0; i < 3; i++) push_flow($urandom());
      drain("berr");
      err_idx = -1;
      check_eq("berr_flag", {31'b0, dma_bus_error}, 32'd1);

      // Reload during a stalled write
      slave_en = 0;
      push_word($urandom());
      push_word($urandom());
      wait_cyc("reload_wait");
      load_base(32'h9000_0200);
      check_eq("reload_cyc", {31'b0, wbm_cyc_o}, 32'd0);
      check_eq("reload_flags", {30'b0, dma_overflow_error, dma_bus_error}, 32'd0);
      check_eq("reload_ptr", dma_wr_pointer_o, 32'h9000_0200);
      slave_en = 1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (wbm_cyc_o) seen = 1;
      end
      check_eq("reload_empty", {31'b0, seen}, 32'd0);
      push_word($urandom());
      drain("reload");

      // Reset mid-cycle with overrun and queued words present
      slave_en = 0;
      for (int i = 0; i < 6; i++) push_word($urandom());
      check_eq("pre_rst_ovf", {31'b0, dma_overflow_error}, 32'd1);
      check_eq("pre_rst_cyc", {31'b0, wbm_cyc_o}, 32'd1);
      do_reset();
      check_reset_state("midrst");

      // Disable during a write: the cycle finishes, no new one starts
      load_base(32'h8000_0100);
      push_word($urandom());
      wait_cyc("dis_wait");
      i2s_enable = 1'b0;
      push_word($urandom());
      max_delay = 2;
      w0 = n_writes;
      slave_en = 1;
      for (int i = 0; i < 20 && n_writes == w0; i++) tick();
      check_eq("dis_done", n_writes - w0, 32'd1);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (wbm_cyc_o) seen = 1;
      end
      check_eq("dis_nocyc", {31'b0, seen}, 32'd0);
      i2s_enable = 1'b1;
      drain("dis");

      // Randomized geometries, data, latency and occasional errors
      for (int r = 0; r < 6; r++) begin
         ws  = ($urandom_range(1, 0) == 1) ? 8 : 4;
         nw  = $urandom_range(16, 3);
         set_geom(ws, ws * nw);
         bl  = $urandom_range((4096 - ws * nw) / 4 - 1, 0) * 4;
         rnd = $urandom();
         rnd[11:0] = 12'(bl);
         load_base(rnd);
         max_delay = $urandom_range(3, 0);
         err_idx   = $urandom_range(2 * nw, 0);
         cnt       = $urandom_range(40, 10);
         for (int i = 0; i < int'(cnt); i++) begin
            repeat ($urandom_range(2, 0)) tick();
            push_flow($urandom());
         end
         drain("rand");
         err_idx = -1;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
